bitser_mac_ctrl: RTL



---
 rtl/bitser_mac_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bitser_mac_ctrl.sv
// bitser_mac_ctrl
//   Sequencer for a bit-serial accumulator built around one external 1-bit
//   full adder. NUM_OPS unsigned operands are summed LSB first, one bit per
//   clock, into an ACC_W-bit accumulator (result wraps mod 2^ACC_W).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          begin accumulation (IDLE only) / return to IDLE
//   in_valid/in_data/in_ready     operand handshake
//   fa_a, fa_b, fa_cin    drives to the external full adder (0 outside ADD)
//   fa_sum, fa_carry      results from the external full adder
//   out_valid/out_data/out_ready  result handshake
//   busy                  high in every state except IDLE
module bitser_mac_ctrl #(
   parameter int DATA_W  = 8,
   parameter int NUM_OPS = 4,
   parameter int ACC_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              fa_a,
   output logic              fa_b,
   output logic              fa_cin,
   input  logic              fa_sum,
   input  logic              fa_carry,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              busy
);

   localparam int CNT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
   localparam int OPC_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(ACC_W - 1);
   localparam logic [OPC_W-1:0] OP_LAST  = OPC_W'(NUM_OPS - 1);

   typedef enum logic [1:0] {IDLE, WAIT_OP, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] op_sr_q, op_sr_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [OPC_W-1:0] op_cnt_q, op_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      op_sr_d     = op_sr_q;
      out_data_d  = out_data_q;
      carry_d     = carry_q;
      bit_cnt_d   = bit_cnt_q;
      op_cnt_d    = op_cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WAIT_OP;
               acc_d      = '0;
               op_cnt_d   = '0;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         WAIT_OP: begin
            if (in_valid && in_ready_q) begin
               state_d    = ADD;
               op_sr_d    = ACC_W'(in_data);
               carry_d    = 1'b0;
               bit_cnt_d  = '0;
               in_ready_d = 1'b0;
            end
         end
         ADD: begin
            // Sum bit enters at the MSB; after ACC_W shifts the
            // accumulator is back in its natural bit order.
            acc_d     = ACC_W'({fa_sum, acc_q} >> 1);
            op_sr_d   = op_sr_q >> 1;
            carry_d   = fa_carry;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               op_cnt_d  = op_cnt_q + 1'b1;
               if (op_cnt_q == OP_LAST) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = acc_d;
               end else begin
                  state_d    = WAIT_OP;
                  in_ready_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over start and over both handshakes.
      if (abort) begin
         state_d     = IDLE;
         acc_d       = '0;
         op_sr_d     = '0;
         out_data_d  = '0;
         carry_d     = 1'b0;
         bit_cnt_d   = '0;
         op_cnt_d    = '0;
         in_ready_d  = 1'b0;
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         op_sr_q     <= '0;
         out_data_q  <= '0;
         carry_q     <= 1'b0;
         bit_cnt_q   <= '0;
         op_cnt_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_sr_q     <= op_sr_d;
         out_data_q  <= out_data_d;
         carry_q     <= carry_d;
         bit_cnt_q   <= bit_cnt_d;
         op_cnt_q    <= op_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // The adder sees the current bit only while adding; otherwise it is quiet.
   assign fa_a   = (state_q == ADD) & acc_q[0];
   assign fa_b   = (state_q == ADD) & op_sr_q[0];
   assign fa_cin = (state_q == ADD) & carry_q;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule
